// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port round-robin arbiter and access sequencer for the single-port data
// memory. Port 0 is the CPU load/store path; port 1 is the loader/debug port.
// A granted request is latched, driven to the memory for WAIT_CYCLES + 1
// BUSY cycles, and completed with a registered one-cycle ack (plus registered
// read data for reads) back to the owning port.
//
// Parameters:
//   WAIT_CYCLES  extra BUSY cycles before the completing cycle (0..15)
//   CNT_W        width of the wait counter, must hold WAIT_CYCLES
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req0/1, we0/1         request (held until ack) and write enable
//   addr0/1, wdata0/1     byte address and write data per port
//   ack0/1, rdata0/1      registered completion pulse and read data per port
//   mem_read, mem_write   memory MemRead / MemWrite
//   mem_addr, mem_wdata   memory address / write data (latched request)
//   mem_rdata             combinational memory read data
//
// Optional build macro DMEM_ARB_STATS_EN adds saturating 16-bit counters:
//   grant_cnt0, grant_cnt1, conflict_cnt
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0] grant_cnt0,
   output logic [15:0] grant_cnt1,
   output logic [15:0] conflict_cnt
`endif
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]       state_r;
   logic             owner_r;
   logic             we_r;
   logic [31:0]      addr_r;
   logic [31:0]      wdata_r;
   logic             last_r;
   logic [CNT_W-1:0] cnt_r;
   logic             ack0_r;
   logic             ack1_r;
   logic [31:0]      rdata0_r;
   logic [31:0]      rdata1_r;

   logic             elig0_s;
   logic             elig1_s;
   logic             grant_s;
   logic             grant_port_s;
   logic             conflict_s;
   logic             done_s;

   // Eligibility and round-robin choice; a port in its ack cycle is never re-granted.
   always_comb begin
      elig0_s    = req0 & ~ack0_r;
      elig1_s    = req1 & ~ack1_r;
      conflict_s = (state_r == ST_IDLE) & elig0_s & elig1_s;
      grant_s    = (state_r == ST_IDLE) & (elig0_s | elig1_s);
      if (elig0_s && elig1_s) begin
         // Tie goes to the port that did not complete most recently.
         grant_port_s = ~last_r;
      end else if (elig1_s) begin
         grant_port_s = 1'b1;
      end else begin
         grant_port_s = 1'b0;
      end
      done_s = (state_r == ST_BUSY) & (cnt_r == {CNT_W{1'b0}});
   end

   // Memory-side drive; the write strobe is combinational so the memory commits on the completing edge.
   always_comb begin
      mem_addr  = addr_r;
      mem_wdata = wdata_r;
      if (state_r == ST_BUSY) begin
         mem_read  = ~we_r;
         mem_write = done_s & we_r;
      end else begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end
   end

   // Sequencer state, request latch, wait counter and registered completion outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         owner_r  <= 1'b0;
         we_r     <= 1'b0;
         addr_r   <= 32'h0000_0000;
         wdata_r  <= 32'h0000_0000;
         last_r   <= 1'b1;
         cnt_r    <= {CNT_W{1'b0}};
         ack0_r   <= 1'b0;
         ack1_r   <= 1'b0;
         rdata0_r <= 32'h0000_0000;
         rdata1_r <= 32'h0000_0000;
      end else begin
         // Acks are pulses: cleared on every edge that does not set them.
         ack0_r <= 1'b0;
         ack1_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (grant_s) begin
                  owner_r <= grant_port_s;
                  we_r    <= grant_port_s ? we1    : we0;
                  addr_r  <= grant_port_s ? addr1  : addr0;
                  wdata_r <= grant_port_s ? wdata1 : wdata0;
                  cnt_r   <= CNT_W'(WAIT_CYCLES);
                  state_r <= ST_BUSY;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (!done_s) begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end else begin
                  if (owner_r) begin
                     ack1_r <= 1'b1;
                     if (!we_r) begin
                        rdata1_r <= mem_rdata;
                     end
                  end else begin
                     ack0_r <= 1'b1;
                     if (!we_r) begin
                        rdata0_r <= mem_rdata;
                     end
                  end
                  last_r  <= owner_r;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack0   = ack0_r;
   assign ack1   = ack1_r;
   assign rdata0 = rdata0_r;
   assign rdata1 = rdata1_r;

`ifdef DMEM_ARB_STATS_EN
   // Saturating increment used by the statistics counters.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

   // Grant and conflict statistics, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt0   <= 16'h0000;
         grant_cnt1   <= 16'h0000;
         conflict_cnt <= 16'h0000;
      end else begin
         if (grant_s && !grant_port_s) begin
            grant_cnt0 <= sat_inc16(grant_cnt0);
         end
         if (grant_s && grant_port_s) begin
            grant_cnt1 <= sat_inc16(grant_cnt1);
         end
         if (conflict_s) begin
            conflict_cnt <= sat_inc16(conflict_cnt);
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter with WAIT_CYCLES = 1. A small word memory stands in
// for the data memory. A transaction-level reference model (absolute cycle
// numbers for grant/complete/ack, a reference memory array) predicts every
// output each cycle; directed sequences add explicit cycle-by-cycle checks.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int W = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = 32'h0, addr1 = 32'h0, wdata0 = 32'h0, wdata1 = 32'h0;
   logic        ack0, ack1, mem_read, mem_write;
   logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif

   dmem_arbiter #(.WAIT_CYCLES(W), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
      , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Data memory stand-in: combinational read, write on posedge.
   logic [31:0] tmem [16] = '{default: 32'h0};
   assign mem_rdata = tmem[mem_addr[5:2]];
   always @(posedge clk) begin
      if (mem_write) tmem[mem_addr[5:2]] <= mem_wdata;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      else n_pass++;
   endtask

   // ---------------- reference model ----------------
   int          t = 0;
   bit          m_ok = 1'b0;
   bit          m_act = 1'b0;
   int          m_comp = 0;
   bit          m_own = 1'b0, m_we = 1'b0, m_last = 1'b1;
   logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
   bit          e_ack0 = 1'b0, e_ack1 = 1'b0;
   logic [31:0] e_rd0 = 32'h0, e_rd1 = 32'h0;
   logic [31:0] ref_mem [16] = '{default: 32'h0};
   int          m_g0 = 0, m_g1 = 0, m_conf = 0;
   bit          done, el0, el1, gp, n_ack0, n_ack1;

   always @(negedge clk) begin
      t = t + 1;
      done = m_act && (t == m_comp);
      if (m_ok) begin
         check_val("ack0", 32'(ack0), 32'(e_ack0));
         check_val("ack1", 32'(ack1), 32'(e_ack1));
         check_val("rdata0", rdata0, e_rd0);
         check_val("rdata1", rdata1, e_rd1);
         check_val("mem_read", 32'(mem_read), 32'(m_act && !m_we));
         check_val("mem_write", 32'(mem_write), 32'(done && m_we));
         check_val("mem_addr", mem_addr, m_addr);
         check_val("mem_wdata", mem_wdata, m_wdata);
`ifdef DMEM_ARB_STATS_EN
         check_val("grant_cnt0", 32'(grant_cnt0), 32'(m_g0));
         check_val("grant_cnt1", 32'(grant_cnt1), 32'(m_g1));
         check_val("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
`endif
      end
      n_ack0 = 1'b0;
      n_ack1 = 1'b0;
      if (m_ok && done) begin
         if (m_own) n_ack1 = 1'b1; else n_ack0 = 1'b1;
         if (m_we) ref_mem[m_addr[5:2]] = m_wdata;
         else if (m_own) e_rd1 = ref_mem[m_addr[5:2]];
         else e_rd0 = ref_mem[m_addr[5:2]];
         m_last = m_own;
         m_act  = 1'b0;
      end else if (m_ok && !m_act) begin
         el0 = req0 && !e_ack0;
         el1 = req1 && !e_ack1;
         if (el0 && el1) begin
            m_conf++;
            gp = !m_last;
         end else begin
            gp = el1;
         end
         if (el0 || el1) begin
            m_act   = 1'b1;
            m_own   = gp;
            m_we    = gp ? we1 : we0;
            m_addr  = gp ? addr1 : addr0;
            m_wdata = gp ? wdata1 : wdata0;
            m_comp  = t + W + 1;   // BUSY for W+1 cycles after the grant cycle
            if (gp) m_g1++; else m_g0++;
         end
      end
      e_ack0 = n_ack0;
      e_ack1 = n_ack1;
      if (reset) begin
         m_ok = 1'b1; m_act = 1'b0; m_own = 1'b0; m_we = 1'b0; m_last = 1'b1;
         m_addr = 32'h0; m_wdata = 32'h0; e_ack0 = 1'b0; e_ack1 = 1'b0;
         e_rd0 = 32'h0; e_rd1 = 32'h0; m_g0 = 0; m_g1 = 0; m_conf = 0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic step_port(input logic ack, inout logic req, inout logic we,
                            inout logic [31:0] addr, inout logic [31:0] wdata);
      if (!req) begin
         if ($urandom_range(2) == 0) begin
            req = 1'b1; we = 1'($urandom_range(1));
            addr = {26'd0, 4'($urandom_range(15)), 2'b00}; wdata = $urandom;
         end
      end else if (ack) begin
         if ($urandom_range(3) != 0) req = 1'b0;
      end else if ($urandom_range(15) == 0) begin
         req = 1'b0;
      end else if ($urandom_range(7) == 0) begin
         we = 1'($urandom_range(1));
         addr = {26'd0, 4'($urandom_range(15)), 2'b00}; wdata = $urandom;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Write DEADBEEF to addr 8 from port 0.
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'd8; wdata0 = 32'hDEADBEEF;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_val("wr_mem_write", 32'(mem_write), 32'(c == 2));
         check_val("wr_ack0", 32'(ack0), 32'(c == 3));
         check_val("wr_ack1", 32'(ack1), 32'd0);
         next_cycle();
         if (c == 3) req0 = 1'b0;
      end

      // Read it back on port 0.
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8; wdata0 = 32'h0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_val("rd_ack0", 32'(ack0), 32'(c == 3));
         if (c == 3) begin
            check_val("rd_rdata0", rdata0, 32'hDEADBEEF);
            check_val("rd_rdata1", rdata1, 32'h0);
         end
         next_cycle();
         if (c == 3) req0 = 1'b0;
      end

      // Both ports request together right after reset and hold: 0,1,0,1,0,1.
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
      for (int c = 0; c < 21; c++) begin
         @(negedge clk);
         check_val("rr_ack0", 32'(ack0), 32'(c == 3 || c == 9 || c == 15));
         check_val("rr_ack1", 32'(ack1), 32'(c == 6 || c == 12 || c == 18));
         check_val("rr_ack_both", 32'(ack0 & ack1), 32'd0);
         check_val("rr_mem_read", 32'(mem_read), 32'(c >= 1 && c <= 17 && (c % 3) != 0));
         next_cycle();
         if (c == 15) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
      end
`ifdef DMEM_ARB_STATS_EN
      // Three grants each; only the very first IDLE cycle had both eligible.
      check_val("st_grant0", 32'(grant_cnt0), 32'd3);
      check_val("st_grant1", 32'(grant_cnt1), 32'd3);
      check_val("st_conflict", 32'(conflict_cnt), 32'd1);
`endif

      // Port 1 holds req through its ack cycle: one access only.
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'd8;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check_val("hold_ack1", 32'(ack1), 32'(c == 3));
         check_val("hold_ack0", 32'(ack0), 32'd0);
         check_val("hold_mem_read", 32'(mem_read), 32'(c == 1 || c == 2));
         if (c == 3) check_val("hold_rdata1", rdata1, 32'hDEADBEEF);
         next_cycle();
         if (c == 3) req1 = 1'b0;
      end

      // Reset in the first BUSY cycle of a write to addr 12.
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'd12; wdata0 = 32'h12345678;
      @(negedge clk);
      check_val("rst_mw_c0", 32'(mem_write), 32'd0);
      next_cycle();
      reset = 1'b1; req0 = 1'b0;
      @(negedge clk);
      check_val("rst_mw_c1", 32'(mem_write), 32'd0);
      next_cycle();
      reset = 1'b0;
      for (int c = 2; c < 6; c++) begin
         @(negedge clk);
         check_val("rst_mem_write", 32'(mem_write), 32'd0);
         check_val("rst_mem_read", 32'(mem_read), 32'd0);
         check_val("rst_ack", 32'({ack0, ack1}), 32'd0);
         check_val("rst_mem_addr", mem_addr, 32'h0);
         check_val("rst_mem_wdata", mem_wdata, 32'h0);
         check_val("rst_rdata0", rdata0, 32'h0);
         check_val("rst_rdata1", rdata1, 32'h0);
         next_cycle();
      end
      check_val("rst_mem_unchanged", tmem[3], 32'h0);

      // Randomized traffic checked by the reference model.
      for (int i = 0; i < 3000; i++) begin
         if (reset) reset = 1'b0;
         else if ($urandom_range(399) == 0) reset = 1'b1;
         step_port(ack0, req0, we0, addr0, wdata0);
         step_port(ack1, req1, we1, addr1, wdata1);
         next_cycle();
      end
      req0 = 1'b0; req1 = 1'b0; reset = 1'b0;
      repeat (6) next_cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
